// File: rtl/ddr_sim_mem.sv
// ddr_sim_mem: cycle-timed DDR line memory model.
// Accepts one chip-enable request while idle. It stalls for a programmed latency,
// then commits a masked 512-bit write or returns a 512-bit read line, and finally
// pulses ddr_operation_done for one cycle.
// Optional feature macro: DDR_SIM_RAND_LAT_EN. When it is defined, an LFSR adds
// 0..7 extra cycles of latency to each request.
module ddr_sim_mem #(
    parameter int MEM_DEPTH_LOG2 = 16,
    parameter int READ_LATENCY   = 8,
    parameter int WRITE_LATENCY  = 4,
    parameter int BURST_EXTRA    = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ddr_chip_enable,
    input  logic [63:0]  ddr_index,
    input  logic         ddr_write_enable,
    input  logic         ddr_burst_mode,
    input  logic [511:0] ddr_write_mask,
    input  logic [511:0] ddr_write_data,
    output logic [511:0] ddr_read_data,
    output logic         ddr_operation_done,
    output logic         ddr_ready
);

`ifdef DDR_SIM_RAND_LAT_EN
    localparam int RAND_MAX = 7;
`else
    localparam int RAND_MAX = 0;
`endif
    localparam int MAX_LAT = ((READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY)
                             + BURST_EXTRA + RAND_MAX;
    localparam int CW = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             counter;
    logic [CW-1:0]             req_lat;
    logic [MEM_DEPTH_LOG2-1:0] lat_line;
    logic                      lat_we;
    logic [511:0]              lat_mask;
    logic [511:0]              lat_data;
    logic [511:0]              mem [0:(2**MEM_DEPTH_LOG2)-1];

    logic                      accept;
    logic                      commit_now;
    logic [MEM_DEPTH_LOG2-1:0] c_line;
    logic                      c_we;
    logic [511:0]              c_mask;
    logic [511:0]              c_data;
    logic                      unused_idx_bits;

    // Offset and high address bits do not select a line, so addresses alias.
    assign unused_idx_bits = ^{ddr_index[63:6+MEM_DEPTH_LOG2], ddr_index[5:0]};

    assign accept = ddr_chip_enable & ddr_ready;

`ifdef DDR_SIM_RAND_LAT_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) that jitters the latency.
    always_ff @(posedge clock) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    // Latency of the request currently presented on the inputs.
    always_comb begin
        req_lat = ddr_write_enable ? CW'(WRITE_LATENCY) : CW'(READ_LATENCY);
        if (ddr_burst_mode) req_lat = req_lat + CW'(BURST_EXTRA);
`ifdef DDR_SIM_RAND_LAT_EN
        req_lat = req_lat + CW'(lfsr[2:0]);
`endif
    end

    // A latency-1 request commits on its accept edge, before the latched copy
    // exists. For that case, the commit takes the live inputs.
    assign c_line = (state == IDLE) ? ddr_index[6 +: MEM_DEPTH_LOG2] : lat_line;
    assign c_we   = (state == IDLE) ? ddr_write_enable : lat_we;
    assign c_mask = (state == IDLE) ? ddr_write_mask   : lat_mask;
    assign c_data = (state == IDLE) ? ddr_write_data   : lat_data;

    assign commit_now = !reset && ((accept && req_lat == CW'(1)) ||
                                   (state == BUSY && counter == CW'(1)));

    // Control FSM: accept, count down the latency, then pulse done for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            ddr_ready          <= 1'b0;
            ddr_operation_done <= 1'b0;
            ddr_read_data      <= '0;
            counter            <= '0;
        end else begin
            ddr_operation_done <= commit_now;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_line  <= ddr_index[6 +: MEM_DEPTH_LOG2];
                        lat_we    <= ddr_write_enable;
                        lat_mask  <= ddr_write_mask;
                        lat_data  <= ddr_write_data;
                        counter   <= req_lat - CW'(1);
                        ddr_ready <= 1'b0;
                        state     <= (req_lat == CW'(1)) ? DONE : BUSY;
                    end else begin
                        ddr_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) state <= DONE;
                end
                default: begin
                    state     <= IDLE;
                    ddr_ready <= 1'b1;
                end
            endcase
            if (commit_now && !c_we) ddr_read_data <= mem[c_line];
        end
    end

    // Masked line write. The backing array is deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (commit_now && c_we)
            mem[c_line] <= (mem[c_line] & ~c_mask) | (c_data & c_mask);
    end

endmodule

// File: tb/tb_ddr_sim_mem.sv
// tb_ddr_sim_mem: directed scenarios plus randomized traffic. Results are checked
// against a line-level memory model and the latency rules.
module tb_ddr_sim_mem;
    localparam int DEPTH = 16;
    localparam int RL = 8, WL = 4, BE = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         ddr_chip_enable;
    logic [63:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [511:0] ddr_write_mask;
    logic [511:0] ddr_write_data;
    logic [511:0] ddr_read_data;
    logic         ddr_operation_done;
    logic         ddr_ready;

    int checks = 0;
    int failures = 0;

    logic [511:0] model_mem [int];
    logic [511:0] exp_rd;

    always #5 clock = ~clock;

    ddr_sim_mem #(
        .MEM_DEPTH_LOG2(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .BURST_EXTRA(BE)
    ) dut (
        .clock(clock), .reset(reset),
        .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
        .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
        .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
        .ddr_ready(ddr_ready)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int line_of(input logic [63:0] idx);
        return int'(idx[6 +: DEPTH]);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scramble request inputs so that only latched fields can matter.
    task automatic scramble();
        ddr_index        = {$urandom, $urandom};
        ddr_write_enable = 1'($urandom);
        ddr_burst_mode   = 1'($urandom);
        ddr_write_mask   = rand512();
        ddr_write_data   = rand512();
    endtask

    // Issue one request and check ready/done/read_data every cycle until idle again.
    // glitch: cycle after which a stray write CE is raised for one edge (-1 = none).
    // abort: cycle after which reset is pulsed for one edge (-1 = none).
    task automatic issue(input logic we, input logic burst, input logic [63:0] idx,
                         input logic [511:0] mask, input logic [511:0] data,
                         input int glitch, input int abort);
        int n;
        int lat;
        logic [511:0] new_rd;
        n = 0;
        while (!ddr_ready && n < 40) begin tick(); n++; end
        chk("ready_wait", ddr_ready, 1'b1);
        ddr_chip_enable  = 1'b1;
        ddr_index        = idx;
        ddr_write_enable = we;
        ddr_burst_mode   = burst;
        ddr_write_mask   = mask;
        ddr_write_data   = data;
        lat = (we ? WL : RL) + (burst ? BE : 0);
        new_rd = exp_rd;
        if (!we) new_rd = model_mem[line_of(idx)];
        tick();
        ddr_chip_enable = 1'b0;
        scramble();
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) tick();
            ddr_chip_enable = 1'b0;
            chk("ready", ddr_ready, (k == lat));
            chk("done", ddr_operation_done, (k == lat - 1));
            if (k == lat - 1) begin
                exp_rd = new_rd;
                if (we) model_mem[line_of(idx)] = (model_mem[line_of(idx)] & ~mask) | (data & mask);
            end
            chk("read_data", ddr_read_data, exp_rd);
            if (k == glitch) begin
                ddr_chip_enable  = 1'b1;
                ddr_write_enable = 1'b1;
                ddr_write_mask   = '1;
                ddr_write_data   = rand512();
            end
            if (k == abort) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                exp_rd = '0;
                chk("abort_ready", ddr_ready, 1'b0);
                chk("abort_done", ddr_operation_done, 1'b0);
                chk("abort_rd", ddr_read_data, exp_rd);
                tick();
                chk("abort_ready1", ddr_ready, 1'b1);
                for (int j = 0; j < lat; j++) begin
                    tick();
                    chk("abort_nodone", ddr_operation_done, 1'b0);
                end
                return;
            end
        end
    endtask

    initial begin
        logic [511:0] a5;
        logic [511:0] t4;
        logic [63:0]  idx;
        int lines [5];
        a5 = {64{8'hA5}};
        t4 = {{60{8'hA5}}, 32'hFFFFFFFF};
        ddr_chip_enable = 1'b0;
        scramble();
        exp_rd = '0;

        // 1. reset for 3 cycles
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", ddr_ready, 1'b0);
            chk("rst_done", ddr_operation_done, 1'b0);
            chk("rst_rd", ddr_read_data, '0);
        end
        reset = 1'b0;
        tick();
        chk("post_rst_ready", ddr_ready, 1'b1);
        chk("post_rst_done", ddr_operation_done, 1'b0);

        // 2. full write
        issue(1'b1, 1'b0, 64'h40, '1, a5, -1, -1);
        // 3. burst read
        issue(1'b0, 1'b1, 64'h40, '0, '0, -1, -1);
        chk("t3_data", ddr_read_data, a5);
        // 4. partial write, then read back
        issue(1'b1, 1'b0, 64'h40, 512'hFFFFFFFF, '1, -1, -1);
        issue(1'b0, 1'b0, 64'h40, '0, '0, -1, -1);
        chk("t4_data", ddr_read_data, t4);
        // 5. read with a stray write CE sampled while busy
        issue(1'b0, 1'b0, 64'h40, '0, '0, 2, -1);
        // 6. read aborted by reset, then aliased read
        issue(1'b0, 1'b0, 64'h40, '0, '0, -1, 2);
        issue(1'b0, 1'b0, 64'h40 + (64'd1 << 22), '0, '0, -1, -1);
        chk("t6_alias", ddr_read_data, t4);

        // Randomized traffic over a few lines, including the top line and aliases
        lines = '{0, 2, 3, 5, 65535};
        foreach (lines[i]) begin
            idx = {$urandom, $urandom};
            idx[6 +: DEPTH] = DEPTH'(lines[i]);
            issue(1'b1, 1'($urandom), idx, '1, rand512(), -1, -1);
        end
        for (int r = 0; r < 40; r++) begin
            logic we;
            idx = {$urandom, $urandom};
            idx[6 +: DEPTH] = DEPTH'(lines[$urandom_range(0, 4)]);
            we = 1'($urandom);
            issue(we, 1'($urandom), idx, rand512(), rand512(),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
